pmem_line_responder: RTL and testbench

Line-granular responder that services L1 cache miss/writeback requests (`pmem_read`/`pmem_write`, 256-bit line, single `pmem_resp` pulse) by driving a 64-bit burst physical-memory port. It sits between the L1 cache controllers and physical memory. It converts one line request into four beats, then returns the assembled line with a one-cycle response. It is the responding end of the L1 `pmem_*` handshake.

---
 rtl/pmem_line_responder_if.sv | 30 +++
 rtl/pmem_line_responder.sv | 128 ++++++++++++
 tb/tb_pmem_line_responder.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pmem_line_responder_if.sv
// Bundles the L1-facing pmem_* line handshake and the 64-bit burst memory port.
// slave: the responder's view; master: the cache/memory environment's view.
interface pmem_line_responder_if #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned BEAT_W = 64,
  parameter int unsigned ADDR_W = 32
);
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;
  logic              burst_read;
  logic              burst_write;
  logic [ADDR_W-1:0] burst_address;
  logic [BEAT_W-1:0] burst_wdata;
  logic [BEAT_W-1:0] burst_rdata;
  logic              burst_resp;

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata, burst_rdata, burst_resp,
    output pmem_rdata, pmem_resp, burst_read, burst_write, burst_address, burst_wdata
  );

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata, burst_rdata, burst_resp,
    input  pmem_rdata, pmem_resp, burst_read, burst_write, burst_address, burst_wdata
  );
endinterface

// File: rtl/pmem_line_responder.sv
// Converts one 256-bit line read/write request into a four-beat 64-bit burst.
// Optional PMEM_LINE_STATS_EN adds stats_clear/read_count/write_count counters.
module pmem_line_responder #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned BEAT_W = 64,
  parameter int unsigned ADDR_W = 32
) (
  input  logic clk,
  input  logic rst_n,
`ifdef PMEM_LINE_STATS_EN
  input  logic        stats_clear,
  output logic [31:0] read_count,
  output logic [31:0] write_count,
`endif
  pmem_line_responder_if.slave bus
);

  localparam int unsigned NBEATS = LINE_W / BEAT_W;
  localparam int unsigned CNT_W  = $clog2(NBEATS);

  // Clears the byte-offset bits so the burst address is line aligned.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(LINE_W/8 - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ_BURST,
    WRITE_BURST,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              op_wr_q, op_wr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      addr_q  <= '0;
      op_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
      op_wr_q <= op_wr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    addr_d  = addr_q;
    op_wr_d = op_wr_q;
    case (state_q)
      IDLE: begin
        if (bus.pmem_read) begin
          addr_d  = bus.pmem_address & ALIGN_MASK;
          op_wr_d = 1'b0;
          state_d = READ_BURST;
        end else if (bus.pmem_write) begin
          addr_d  = bus.pmem_address & ALIGN_MASK;
          line_d  = bus.pmem_wdata;
          op_wr_d = 1'b1;
          state_d = WRITE_BURST;
        end
      end
      READ_BURST: begin
        if (bus.burst_resp) begin
          line_d[BEAT_W*int'(cnt_q) +: BEAT_W] = bus.burst_rdata;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NBEATS-1)) state_d = DONE;
        end
      end
      WRITE_BURST: begin
        if (bus.burst_resp) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NBEATS-1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Burst strobes decode from state alone so an async reset drops them at once.
  assign bus.burst_read    = (state_q == READ_BURST);
  assign bus.burst_write   = (state_q == WRITE_BURST);
  assign bus.burst_address = addr_q;
  assign bus.burst_wdata   = (state_q == WRITE_BURST) ? line_q[BEAT_W*int'(cnt_q) +: BEAT_W] : '0;
  assign bus.pmem_resp     = (state_q == DONE);
  assign bus.pmem_rdata    = line_q;

`ifdef PMEM_LINE_STATS_EN
  logic [31:0] read_count_q, read_count_d;
  logic [31:0] write_count_q, write_count_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_count_q  <= '0;
      write_count_q <= '0;
    end else begin
      read_count_q  <= read_count_d;
      write_count_q <= write_count_d;
    end
  end

  always_comb begin
    read_count_d  = read_count_q;
    write_count_d = write_count_q;
    if (stats_clear) begin
      read_count_d  = '0;
      write_count_d = '0;
    end else if (state_q == DONE) begin
      if (op_wr_q) write_count_d = write_count_q + 32'd1;
      else         read_count_d  = read_count_q + 32'd1;
    end
  end

  assign read_count  = read_count_q;
  assign write_count = write_count_q;
`endif

endmodule

// File: tb/tb_pmem_line_responder.sv
// Directed table-driven bench for pmem_line_responder plus hand sequences for
// write gaps, mid-burst reset and (when PMEM_LINE_STATS_EN is defined) counters.
module tb_pmem_line_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stats_clear = 1'b0;
`ifdef PMEM_LINE_STATS_EN
  logic [31:0] read_count, write_count;
`endif

  always #5 clk = ~clk;

  pmem_line_responder_if #(.LINE_W(256), .BEAT_W(64), .ADDR_W(32)) bus ();

  pmem_line_responder #(.LINE_W(256), .BEAT_W(64), .ADDR_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef PMEM_LINE_STATS_EN
    .stats_clear (stats_clear),
    .read_count  (read_count),
    .write_count (write_count),
`endif
    .bus         (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic         bresp;
    logic [63:0]  brdata;
    logic         exp_resp;
    logic         exp_bread;
    logic         exp_bwrite;
    logic [31:0]  exp_baddr;
    logic         chk_rdata;
    logic [255:0] exp_rdata;
  } vec_t;

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [255:0] wd, input logic br, input logic [63:0] bd,
                              input logic er, input logic eb, input logic ew,
                              input logic [31:0] ea, input logic cr, input logic [255:0] erd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd; v.bresp = br; v.brdata = bd;
    v.exp_resp = er; v.exp_bread = eb; v.exp_bwrite = ew; v.exp_baddr = ea;
    v.chk_rdata = cr; v.exp_rdata = erd;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    bus.burst_resp   = 1'b0;
    bus.burst_rdata  = '0;
  endtask

  // Generic requester + memory: feeds beats of rline whenever a burst is active.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [255:0] wline,
                         input logic [255:0] rline, output logic [255:0] got, output bit ok);
    int bi;
    bi = 0;
    ok = 1'b0;
    got = '0;
    bus.pmem_read    = !wr;
    bus.pmem_write   = wr;
    bus.pmem_address = addr;
    bus.pmem_wdata   = wline;
    for (int c = 0; c < 40 && !ok; c++) begin
      step();
      if (bus.pmem_resp) begin
        ok = 1'b1;
        got = bus.pmem_rdata;
        bus.burst_resp = 1'b0;
      end else if ((bus.burst_read || bus.burst_write) && bi < 4) begin
        bus.burst_resp  = 1'b1;
        bus.burst_rdata = rline[bi*64 +: 64];
        bi++;
      end else begin
        bus.burst_resp = 1'b0;
      end
    end
    step();
    idle_inputs();
  endtask

  localparam logic [63:0] B1 = 64'h1111_1111_1111_1111, B2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] B3 = 64'h3333_3333_3333_3333, B4 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] B5 = 64'h5555_5555_5555_5555, B6 = 64'h6666_6666_6666_6666;
  localparam logic [63:0] B7 = 64'h7777_7777_7777_7777, B8 = 64'h8888_8888_8888_8888;
  localparam logic [63:0] BA = 64'hAAAA_AAAA_AAAA_AAAA, BB = 64'hBBBB_BBBB_BBBB_BBBB;
  localparam logic [63:0] BC = 64'hCCCC_CCCC_CCCC_CCCC, BD = 64'hDDDD_DDDD_DDDD_DDDD;
  localparam logic [63:0] BJ = 64'hDEAD_BEEF_0BAD_F00D;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vq[$];
    logic [255:0] l1, l2, wl, fl, got;
    logic [63:0] wb [4];
    bit ok;
    int resp_cnt;

    l1 = {B4, B3, B2, B1};
    l2 = {B8, B7, B6, B5};
    wl = {BD, BC, BB, BA};
    fl = {64'hF3F3_F3F3_0000_0003, 64'hF2F2_F2F2_0000_0002,
          64'hF1F1_F1F1_0000_0001, 64'hF0F0_F0F0_0000_0000};
    wb[0] = BA; wb[1] = BB; wb[2] = BC; wb[3] = BD;

    // burst_resp in IDLE ignored, read 0x1234 back-to-back, then read+write together
    vq.push_back(mk(0, 0, 32'h0,         256'h0, 1, BJ, 0, 0, 0, 32'h0,         1, 256'h0));
    vq.push_back(mk(1, 0, 32'h0000_1234, 256'h0, 0, BJ, 0, 1, 0, 32'h0000_1220, 0, 256'h0));
    vq.push_back(mk(1, 0, 32'h0000_1234, 256'h0, 1, B1, 0, 1, 0, 32'h0000_1220, 0, 256'h0));
    vq.push_back(mk(1, 0, 32'h0000_1234, 256'h0, 1, B2, 0, 1, 0, 32'h0000_1220, 0, 256'h0));
    vq.push_back(mk(1, 0, 32'h0000_1234, 256'h0, 1, B3, 0, 1, 0, 32'h0000_1220, 0, 256'h0));
    vq.push_back(mk(1, 0, 32'h0000_1234, 256'h0, 1, B4, 1, 0, 0, 32'h0,         1, l1));
    vq.push_back(mk(1, 0, 32'h0000_1234, 256'h0, 1, BJ, 0, 0, 0, 32'h0,         1, l1));
    vq.push_back(mk(1, 1, 32'h0000_ABFF, wl,     0, BJ, 0, 1, 0, 32'h0000_ABE0, 1, l1));
    vq.push_back(mk(1, 1, 32'h0000_ABFF, wl,     1, B5, 0, 1, 0, 32'h0000_ABE0, 0, 256'h0));
    vq.push_back(mk(1, 1, 32'h0000_ABFF, wl,     1, B6, 0, 1, 0, 32'h0000_ABE0, 0, 256'h0));
    vq.push_back(mk(1, 1, 32'h0000_ABFF, wl,     1, B7, 0, 1, 0, 32'h0000_ABE0, 0, 256'h0));
    vq.push_back(mk(1, 1, 32'h0000_ABFF, wl,     1, B8, 1, 0, 0, 32'h0,         1, l2));
    vq.push_back(mk(0, 0, 32'h0,         256'h0, 0, BJ, 0, 0, 0, 32'h0,         1, l2));

    idle_inputs();
    #12;
    check("reset_resp",   256'(bus.pmem_resp), 256'h0);
    check("reset_bread",  256'(bus.burst_read), 256'h0);
    check("reset_bwrite", 256'(bus.burst_write), 256'h0);
    check("reset_baddr",  256'(bus.burst_address), 256'h0);
    check("reset_bwdata", 256'(bus.burst_wdata), 256'h0);
    check("reset_rdata",  bus.pmem_rdata, 256'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < vq.size(); i++) begin
      bus.pmem_read    = vq[i].rd;
      bus.pmem_write   = vq[i].wr;
      bus.pmem_address = vq[i].addr;
      bus.pmem_wdata   = vq[i].wdata;
      bus.burst_resp   = vq[i].bresp;
      bus.burst_rdata  = vq[i].brdata;
      step();
      check($sformatf("v%0d_resp", i),   256'(bus.pmem_resp),   256'(vq[i].exp_resp));
      check($sformatf("v%0d_bread", i),  256'(bus.burst_read),  256'(vq[i].exp_bread));
      check($sformatf("v%0d_bwrite", i), 256'(bus.burst_write), 256'(vq[i].exp_bwrite));
      if (vq[i].exp_bread || vq[i].exp_bwrite)
        check($sformatf("v%0d_baddr", i), 256'(bus.burst_address), 256'(vq[i].exp_baddr));
      if (vq[i].chk_rdata)
        check($sformatf("v%0d_rdata", i), bus.pmem_rdata, vq[i].exp_rdata);
    end

    // Write with two-cycle gaps between beats
    resp_cnt = 0;
    bus.pmem_write   = 1'b1;
    bus.pmem_address = 32'h0000_2047;
    bus.pmem_wdata   = wl;
    step();
    check("wr_bwrite",       256'(bus.burst_write), 256'h1);
    check("wr_bread",        256'(bus.burst_read), 256'h0);
    check("wr_baddr",        256'(bus.burst_address), 256'h0000_2040);
    check("wr_rdata_shows",  bus.pmem_rdata, wl);
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < 2; g++) begin
        bus.burst_resp = 1'b0;
        step();
        if (bus.pmem_resp) resp_cnt++;
        check($sformatf("wr_gap_b%0d", k), 256'(bus.burst_wdata), 256'(wb[k]));
      end
      bus.burst_resp = 1'b1;
      step();
      if (bus.pmem_resp) resp_cnt++;
      if (k < 3) check($sformatf("wr_beat_b%0d", k + 1), 256'(bus.burst_wdata), 256'(wb[k + 1]));
      else       check("wr_done_resp", 256'(bus.pmem_resp), 256'h1);
    end
    bus.burst_resp = 1'b0;
    step();
    if (bus.pmem_resp) resp_cnt++;
    idle_inputs();
    step();
    if (bus.pmem_resp) resp_cnt++;
    check("wr_resp_pulses", 256'(resp_cnt), 256'd1);
    check("wr_idle_bwrite", 256'(bus.burst_write), 256'h0);

    // Async reset two beats into a read
    bus.pmem_read    = 1'b1;
    bus.pmem_address = 32'h0000_3000;
    step();
    bus.burst_resp  = 1'b1;
    bus.burst_rdata = 64'hEEEE_EEEE_EEEE_EEEE;
    step();
    step();
    bus.burst_resp = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_bread", 256'(bus.burst_read), 256'h0);
    check("rst_resp",  256'(bus.pmem_resp), 256'h0);
    check("rst_rdata", bus.pmem_rdata, 256'h0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_txn(1'b0, 32'h0000_3000, 256'h0, fl, got, ok);
    check("rst_next_ok",    256'(ok), 256'h1);
    check("rst_next_rdata", got, fl);

`ifdef PMEM_LINE_STATS_EN
    rst_n = 1'b0;
    #3;
    check("stats_rst_rd", 256'(read_count), 256'h0);
    check("stats_rst_wr", 256'(write_count), 256'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int t = 0; t < 5; t++) begin
      run_txn(t == 1 || t == 3, 32'h0000_4000 + 32'(t * 32), wl, l1, got, ok);
      check($sformatf("stats_txn%0d_ok", t), 256'(ok), 256'h1);
    end
    check("stats_rd3", 256'(read_count), 256'd3);
    check("stats_wr2", 256'(write_count), 256'd2);
    bus.pmem_read = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      bus.burst_resp  = 1'b1;
      bus.burst_rdata = wb[k];
      step();
    end
    check("stats_done_resp", 256'(bus.pmem_resp), 256'h1);
    bus.burst_resp = 1'b0;
    stats_clear = 1'b1;
    step();
    stats_clear = 1'b0;
    idle_inputs();
    check("stats_clear_rd", 256'(read_count), 256'h0);
    check("stats_clear_wr", 256'(write_count), 256'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
